matrix_slot_store: RTL

Matrix storage and slot allocator that sits directly downstream of the UART input/generation stage. It grants a base address on request and absorbs the stage's write stream of (address, data) pairs. On commit it records the matrix as valid with its dimensions. It provides a registered read port and a per-slot metadata query for the compute/display stages.

---
 rtl/matrix_slot_store.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/matrix_slot_store.sv
// Matrix slot allocator and word store fed by the UART input stage.
// Grants a slot base per request, gates the fill stream to that slot's window and tracks committed slots.
module matrix_slot_store #(
    parameter int SLOT_CNT  = 8,
    parameter int SLOT_SIZE = 25,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    input  logic [2:0]        alloc_m,
    input  logic [2:0]        alloc_n,
    output logic [ADDR_W-1:0] base_addr,
    output logic              addr_ready,
    output logic [3:0]        alloc_slot,
    output logic              alloc_err,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_oob,
    input  logic              commit,
    input  logic              abort,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [3:0]        q_slot,
    output logic              q_valid,
    output logic [2:0]        q_m,
    output logic [2:0]        q_n,
    output logic [4:0]        valid_count
);
    // state | meaning
    // IDLE  | waiting for a legal alloc_req
    // ALLOC | picking a free slot (or evicting the victim) and publishing its base
    // FILL  | accepting writes inside the granted window until commit/abort
    typedef enum logic [1:0] {IDLE, ALLOC, FILL} state_t;

    localparam int SLOT_W = (SLOT_CNT > 1) ? $clog2(SLOT_CNT) : 1;

    state_t              state;
    logic [2:0]          dim_m;
    logic [2:0]          dim_n;
    logic [SLOT_CNT-1:0] slot_valid;
    logic [2:0]          slot_m [SLOT_CNT];
    logic [2:0]          slot_n [SLOT_CNT];
    logic [SLOT_W-1:0]   victim_ptr;
    logic [SLOT_W-1:0]   cur_slot;
    logic [SLOT_W-1:0]   pick;
    logic                free_found;
    logic [4:0]          mn;
    logic [ADDR_W:0]     win_end;
    logic                wr_accept;
    logic                dims_ok;
    logic                q_in_range;
    logic [SLOT_W-1:0]   q_idx;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    // Lowest-index free slot wins; the victim pointer is only a fallback when all are taken.
    always_comb begin
        free_found = 1'b0;
        pick       = victim_ptr;
        for (int i = SLOT_CNT - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                pick       = SLOT_W'(i);
            end
        end
    end

    assign dims_ok    = (alloc_m != 3'd0) && (alloc_m <= 3'd5) &&
                        (alloc_n != 3'd0) && (alloc_n <= 3'd5);
    assign mn         = {2'b00, dim_m} * {2'b00, dim_n};
    assign win_end    = {1'b0, base_addr} + (ADDR_W + 1)'(mn);
    assign wr_accept  = (state == FILL) && wr_en &&
                        (wr_addr >= base_addr) && ({1'b0, wr_addr} < win_end);
    assign q_in_range = {1'b0, q_slot} < 5'(SLOT_CNT);
    assign q_idx      = q_slot[SLOT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dim_m       <= '0;
            dim_n       <= '0;
            slot_valid  <= '0;
            victim_ptr  <= '0;
            cur_slot    <= '0;
            base_addr   <= '0;
            addr_ready  <= 1'b0;
            alloc_slot  <= '0;
            alloc_err   <= 1'b0;
            busy        <= 1'b0;
            wr_oob      <= 1'b0;
            q_valid     <= 1'b0;
            q_m         <= '0;
            q_n         <= '0;
            valid_count <= '0;
            for (int i = 0; i < SLOT_CNT; i++) begin
                slot_m[i] <= '0;
                slot_n[i] <= '0;
            end
        end else begin
            addr_ready <= 1'b0;
            alloc_err  <= 1'b0;
            wr_oob     <= wr_en && !wr_accept;
            case (state)
                IDLE: begin
                    if (alloc_req) begin
                        if (dims_ok) begin
                            dim_m <= alloc_m;
                            dim_n <= alloc_n;
                            busy  <= 1'b1;
                            state <= ALLOC;
                        end else begin
                            alloc_err <= 1'b1;
                        end
                    end
                end
                ALLOC: begin
                    slot_valid[pick] <= 1'b0;
                    if (!free_found)
                        victim_ptr <= victim_ptr + 1'b1;
                    cur_slot   <= pick;
                    base_addr  <= ADDR_W'(int'(pick) * SLOT_SIZE);
                    alloc_slot <= 4'(pick);
                    addr_ready <= 1'b1;
                    state      <= FILL;
                end
                FILL: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (commit) begin
                        slot_valid[cur_slot] <= 1'b1;
                        slot_m[cur_slot]     <= dim_m;
                        slot_n[cur_slot]     <= dim_n;
                        busy                 <= 1'b0;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            q_valid     <= q_in_range && slot_valid[q_idx];
            q_m         <= (q_in_range && slot_valid[q_idx]) ? slot_m[q_idx] : 3'd0;
            q_n         <= (q_in_range && slot_valid[q_idx]) ? slot_n[q_idx] : 3'd0;
            valid_count <= 5'($countones(slot_valid));
        end
    end

    // Storage is deliberately not reset; stale words simply become unreachable.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= mem[rd_addr];
        end
    end
endmodule
